coreaxitoahbl_write_byte_cnt: RTL and testbench



---
 rtl/coreaxitoahbl_write_byte_cnt_if.sv | 26 ++
 rtl/coreaxitoahbl_write_byte_cnt.sv | 146 ++++++++++++++
 tb/tb_coreaxitoahbl_write_byte_cnt.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/coreaxitoahbl_write_byte_cnt_if.sv
// rtl/coreaxitoahbl_write_byte_cnt_if.sv - AXI write-data channel bundle (WVALID/WREADY/WSTRB/WLAST)
// The master drives beats; the slave (byte counter) returns WREADY.
interface coreaxitoahbl_write_byte_cnt_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic              WVALID;
    logic              WREADY;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;

    modport master (
        output WVALID,
        output WSTRB,
        output WLAST,
        input  WREADY
    );

    modport slave (
        input  WVALID,
        input  WSTRB,
        input  WLAST,
        output WREADY
    );
endinterface

// File: rtl/coreaxitoahbl_write_byte_cnt.sv
// rtl/coreaxitoahbl_write_byte_cnt.sv - counts strobed bytes of one AXI write burst against (8-offset)*(len+1)
// Optional WLAST consistency check: define COREAXITOAHBL_WLAST_CHECK_EN.
module coreaxitoahbl_write_byte_cnt #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           start,
    input  logic [2:0]                     addrOffset,
    input  logic [$clog2(MAX_BEATS)-1:0]   burstLen,
    input  logic                           hold,
    coreaxitoahbl_write_byte_cnt_if.slave  w,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     validBytes,
    output logic [7:0]                     expBytes,
    output logic                           sparse,
    output logic                           lenError
);
    localparam int LEN_W  = $clog2(MAX_BEATS);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [2:0]         r_offset;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic [7:0]         r_valid_bytes;
    logic [7:0]         r_exp_bytes;
    logic               r_sparse;
    logic               r_done;
    logic               r_busy;

    logic               w_xfer;
    logic               w_last_beat;
    logic [3:0]         w_popcnt;
    logic [STRB_W-1:0]  w_exp_mask;
    logic [7:0]         w_bytes_per_beat;
    logic [7:0]         w_num_beats;
    logic [7:0]         w_exp_bytes;

    assign w.WREADY = (r_state == S_DATA) & ~hold;
    assign w_xfer   = w.WVALID & w.WREADY;

    // Length is counted, not signalled: the beat at index len always ends the burst.
    assign w_last_beat = (r_beat_cnt == r_len);
    assign w_exp_mask  = {STRB_W{1'b1}} << r_offset;

    // Operands are at most 8 and 16, so the product never exceeds 128.
    assign w_bytes_per_beat = 8'd8 - {5'd0, addrOffset};
    assign w_num_beats      = {{(8-LEN_W){1'b0}}, burstLen} + 8'd1;
    assign w_exp_bytes      = w_bytes_per_beat * w_num_beats;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_popcnt = w_popcnt + {3'd0, w.WSTRB[i]};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= S_IDLE;
            r_offset      <= '0;
            r_len         <= '0;
            r_beat_cnt    <= '0;
            r_valid_bytes <= '0;
            r_exp_bytes   <= '0;
            r_sparse      <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_offset      <= addrOffset;
                        r_len         <= burstLen;
                        r_beat_cnt    <= '0;
                        r_valid_bytes <= '0;
                        r_sparse      <= 1'b0;
                        r_exp_bytes   <= w_exp_bytes;
                        r_busy        <= 1'b1;
                        r_state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_valid_bytes <= r_valid_bytes + {4'd0, w_popcnt};
                        if (w.WSTRB != w_exp_mask) begin
                            r_sparse <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COREAXITOAHBL_WLAST_CHECK_EN
    logic r_len_error;

    // An early WLAST is only flagged; the burst still runs to len+1 beats.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_len_error <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_len_error <= 1'b0;
        end else if (r_state == S_DATA && w_xfer && (w.WLAST != w_last_beat)) begin
            r_len_error <= 1'b1;
        end
    end

    assign lenError = r_len_error;
`else
    assign lenError = 1'b0;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign validBytes = r_valid_bytes;
    assign expBytes   = r_exp_bytes;
    assign sparse     = r_sparse;
endmodule

// File: tb/tb_coreaxitoahbl_write_byte_cnt.sv
// tb/tb_coreaxitoahbl_write_byte_cnt.sv - directed and randomized bursts checked against a byte-count model
module tb_coreaxitoahbl_write_byte_cnt;
    logic       ACLK;
    logic       ARESET;
    logic       start;
    logic [2:0] addrOffset;
    logic [3:0] burstLen;
    logic       hold;
    logic       busy;
    logic       done;
    logic [7:0] validBytes;
    logic [7:0] expBytes;
    logic       sparse;
    logic       lenError;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] tb_strb [16];
    logic       tb_last [16];

    coreaxitoahbl_write_byte_cnt_if #(.DATA_WIDTH(64)) wif ();

    coreaxitoahbl_write_byte_cnt #(
        .DATA_WIDTH (64),
        .MAX_BEATS  (16)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .start      (start),
        .addrOffset (addrOffset),
        .burstLen   (burstLen),
        .hold       (hold),
        .w          (wif.slave),
        .busy       (busy),
        .done       (done),
        .validBytes (validBytes),
        .expBytes   (expBytes),
        .sparse     (sparse),
        .lenError   (lenError)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_count(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // hold_mode: 0 none, 1 toggle each cycle, 2 random (also injects ignored starts); vmode: 0 always valid, 1 random
    task automatic run_burst(input logic [2:0] off, input logic [3:0] len, input int hold_mode, input int vmode);
        int         beat = 0;
        int         cycles = 0;
        int         exp_bytes;
        int         exp_valid = 0;
        bit         exp_sparse = 0;
        bit         exp_le = 0;
        int         mask;
        mask      = (256 - (1 << off)) & 255;
        exp_bytes = (8 - off) * (len + 1);
        for (int i = 0; i <= len; i++) begin
            exp_valid += bit_count(tb_strb[i]);
            if (tb_strb[i] != mask[7:0]) exp_sparse = 1;
            if (tb_last[i] != (i == len)) exp_le = 1;
        end
`ifndef COREAXITOAHBL_WLAST_CHECK_EN
        exp_le = 0;
`endif
        @(negedge ACLK);
        start = 1'b1; addrOffset = off; burstLen = len;
        @(negedge ACLK);
        start = 1'b0;
        check("busy_data", busy, 1);
        while (beat <= len && cycles < 400) begin
            hold        = (hold_mode == 1) ? cycles[0] : (hold_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            wif.WVALID  = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            wif.WSTRB   = tb_strb[beat];
            wif.WLAST   = tb_last[beat];
            if (hold_mode == 2) begin
                start = $urandom_range(0, 1); addrOffset = 3'($urandom); burstLen = 4'($urandom);
            end
            #1;
            check("wready", wif.WREADY, !hold);
            check("done_mid", done, 0);
            if (wif.WVALID && !hold) beat++;
            cycles++;
            @(negedge ACLK);
        end
        check("burst_timeout", (cycles < 400), 1);
        wif.WVALID = 1'b0; hold = 1'b0;
        check("done_pulse", done, 1);
        check("wready_done", wif.WREADY, 0);
        check("busy_done", busy, 1);
        check("validBytes", validBytes, exp_valid);
        check("expBytes", expBytes, exp_bytes);
        check("sparse", sparse, exp_sparse);
        check("lenError", lenError, exp_le);
        start = 1'b1; addrOffset = 3'($urandom); burstLen = 4'($urandom);
        @(negedge ACLK);
        start = 1'b0;
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("validBytes_hold", validBytes, exp_valid);
        check("expBytes_hold", expBytes, exp_bytes);
        check("sparse_hold", sparse, exp_sparse);
    endtask

    initial begin
        start = 0; addrOffset = 0; burstLen = 0; hold = 0;
        wif.WVALID = 0; wif.WSTRB = 0; wif.WLAST = 0;
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_wready", wif.WREADY, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_validBytes", validBytes, 0);
        check("rst_expBytes", expBytes, 0);
        check("rst_sparse", sparse, 0);
        check("rst_lenError", lenError, 0);
        ARESET = 1'b0;

        // offset 0, len 3, full strobes
        for (int i = 0; i < 16; i++) begin tb_strb[i] = 8'hFF; tb_last[i] = (i == 3); end
        run_burst(3'd0, 4'd3, 0, 0);

        // offset 3, len 1
        tb_strb[0] = 8'hF8; tb_strb[1] = 8'hF8; tb_last[0] = 0; tb_last[1] = 1;
        run_burst(3'd3, 4'd1, 0, 0);

        // partial and zero strobes, zero-strobe last beat
        tb_strb[0] = 8'hFF; tb_strb[1] = 8'h0F; tb_strb[2] = 8'h00;
        tb_last[0] = 0; tb_last[1] = 0; tb_last[2] = 1;
        run_burst(3'd0, 4'd2, 0, 0);

        // 16 beats under toggling back-pressure
        for (int i = 0; i < 16; i++) begin tb_strb[i] = 8'hFF; tb_last[i] = (i == 15); end
        run_burst(3'd0, 4'd15, 1, 0);

        // early WLAST on beat 2 of 4
        for (int i = 0; i < 16; i++) begin tb_strb[i] = 8'hFF; tb_last[i] = (i == 1); end
        run_burst(3'd0, 4'd3, 0, 0);

        // reset after two of four beats
        @(negedge ACLK);
        start = 1'b1; addrOffset = 3'd0; burstLen = 4'd3;
        @(negedge ACLK);
        start = 1'b0; wif.WVALID = 1'b1; wif.WSTRB = 8'hFF; wif.WLAST = 1'b0;
        repeat (2) @(negedge ACLK);
        wif.WVALID = 1'b0; ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("mrst_wready", wif.WREADY, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_validBytes", validBytes, 0);
        check("mrst_expBytes", expBytes, 0);
        @(negedge ACLK);
        check("mrst_no_done", done, 0);
        check("mrst_idle", busy, 0);
        tb_strb[0] = 8'h80; tb_last[0] = 1'b1;
        run_burst(3'd7, 4'd0, 0, 0);

        // randomized bursts
        for (int n = 0; n < 30; n++) begin
            logic [2:0] off;
            logic [3:0] len;
            logic [7:0] m;
            off = 3'($urandom);
            len = 4'($urandom);
            m   = 8'hFF << off;
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 7))
                    0:       tb_strb[i] = 8'h00;
                    1, 2:    tb_strb[i] = 8'($urandom);
                    default: tb_strb[i] = m;
                endcase
                tb_last[i] = ($urandom_range(0, 9) == 0) ? ~(i == len) : (i == len);
            end
            run_burst(off, len, $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
